// File: rtl/seq_multiplier.sv
// rtl/seq_multiplier.sv - iterative shift-add multiplier for RV32M MUL/MULH/MULHSU/MULHU
// One partial product per cycle through a ripple-carry chain; sign is fixed up at the end.
module seq_multiplier #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int PW = 2 * XLEN;
  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  logic [XLEN-1:0]   r_mcand;
  logic [XLEN-1:0]   r_mplier;
  logic [PW-1:0]     r_acc;
  logic [CNT_W-1:0]  r_cnt;
  logic [1:0]        r_op;
  logic              r_neg;
  logic              r_busy;
  logic              r_done;
  logic [XLEN-1:0]   r_result;

  logic              w_a_signed;
  logic              w_b_signed;
  logic              w_a_neg;
  logic              w_b_neg;
  logic [XLEN-1:0]   w_a_mag;
  logic [XLEN-1:0]   w_b_mag;
  logic [XLEN-1:0]   w_acc_hi;
  logic [XLEN-1:0]   w_addend;
  logic [XLEN-1:0]   w_sum;
  logic [XLEN:0]     w_carry;
  logic [PW-1:0]     w_acc_next;
  logic [PW-1:0]     w_prod;

  assign w_a_signed = (op == OP_MULH) || (op == OP_MULHSU);
  assign w_b_signed = (op == OP_MULH);
  assign w_a_neg    = w_a_signed & rs1[XLEN-1];
  assign w_b_neg    = w_b_signed & rs2[XLEN-1];
  // INT_MIN negates to itself, which is already the correct unsigned magnitude.
  assign w_a_mag    = w_a_neg ? (~rs1 + {{(XLEN-1){1'b0}}, 1'b1}) : rs1;
  assign w_b_mag    = w_b_neg ? (~rs2 + {{(XLEN-1){1'b0}}, 1'b1}) : rs2;

  assign w_acc_hi   = r_acc[PW-1:XLEN];
  assign w_addend   = r_mplier[0] ? r_mcand : '0;
  assign w_carry[0] = 1'b0;

  for (genvar gi = 0; gi < XLEN; gi++) begin : g_fa
    assign w_sum[gi]       = w_acc_hi[gi] ^ w_addend[gi] ^ w_carry[gi];
    assign w_carry[gi + 1] = (w_acc_hi[gi] & w_addend[gi]) |
                             (w_carry[gi] & (w_acc_hi[gi] ^ w_addend[gi]));
  end

  // {carry, sum, acc_lo} shifted right by one; the carry becomes the new MSB.
  assign w_acc_next = {w_carry[XLEN], w_sum, r_acc[XLEN-1:1]};
  assign w_prod     = r_neg ? (~r_acc + {{(PW-1){1'b0}}, 1'b1}) : r_acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_op     <= OP_MUL;
      r_neg    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
    end else if (flush) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mcand  <= w_a_mag;
            r_mplier <= w_b_mag;
            r_op     <= op;
            r_neg    <= w_a_neg ^ w_b_neg;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_state  <= S_BUSY;
          end
        end
        S_BUSY: begin
          r_acc    <= w_acc_next;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
          if (r_cnt == CNT_W'(XLEN - 1)) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_result <= (r_op == OP_MUL) ? w_prod[XLEN-1:0] : w_prod[PW-1:XLEN];
          r_done   <= 1'b1;
          r_busy   <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;

endmodule

// File: tb/tb_seq_multiplier.sv
// tb/tb_seq_multiplier.sv - directed vector bench for seq_multiplier
// Table-driven operand/result vectors plus hand-written flush, reset and ignored-start sequences.
module tb_seq_multiplier;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] rs1 = '0;
  logic [31:0] rs2 = '0;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int n_pass  = 0;
  int n_total = 0;

  seq_multiplier #(.XLEN(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .flush(flush), .op(op),
    .rs1(rs1), .rs2(rs2), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Issues start, scrambles operands after sampling, returns latency in edges after E0.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic busy_mid);
    start = 1'b1; op = o; rs1 = a; rs2 = b;
    @(posedge clk); #1;
    start = 1'b0; rs1 = 32'hDEADBEEF; rs2 = 32'h5A5A5A5A; op = ~o;
    lat = 0;
    busy_mid = 1'b0;
    while (lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) busy_mid = busy;
      if (done) break;
    end
  endtask

  int   lat;
  int   pulses;
  logic bm;

  initial begin
    vecs[0]  = '{"mul_7x6",          2'b00, 32'd7,        32'd6,        32'h0000002A};
    vecs[1]  = '{"mulh_m1x2",        2'b01, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF};
    vecs[2]  = '{"mul_m1x2",         2'b00, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE};
    vecs[3]  = '{"mulhu_ffxff",      2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
    vecs[4]  = '{"mulhsu_ffxff",     2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    vecs[5]  = '{"mulh_min_min",     2'b01, 32'h80000000, 32'h80000000, 32'h40000000};
    vecs[6]  = '{"mulhsu_min_x2",    2'b10, 32'h80000000, 32'h00000002, 32'hFFFFFFFF};
    vecs[7]  = '{"mul_by_zero",      2'b00, 32'h12345678, 32'h00000000, 32'h00000000};
    vecs[8]  = '{"mulhu_min_x2",     2'b11, 32'h80000000, 32'h00000002, 32'h00000001};
    vecs[9]  = '{"mulh_max_max",     2'b01, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF};
    vecs[10] = '{"mul_m3x5",         2'b00, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFF1};

    #12;
    check("rst_busy",   {31'd0, busy}, 32'd0);
    check("rst_done",   {31'd0, done}, 32'd0);
    check("rst_result", result, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, bm);
      check({vecs[i].name, "_latency"}, lat, 32'd33);
      check({vecs[i].name, "_busy"}, {31'd0, bm}, 32'd1);
      check({vecs[i].name, "_result"}, result, vecs[i].exp);
      @(posedge clk); #1;
      check({vecs[i].name, "_busy_after"}, {31'd0, busy}, 32'd0);
      check({vecs[i].name, "_done_after"}, {31'd0, done}, 32'd0);
    end

    // Second start during BUSY must be ignored.
    start = 1'b1; op = 2'b00; rs1 = 32'd9; rs2 = 32'd11;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    pulses = 0;
    while (lat < 100) begin
      if (lat == 10) begin start = 1'b1; rs1 = 32'd100; rs2 = 32'd200; end
      else start = 1'b0;
      @(posedge clk); #1;
      lat++;
      if (done) break;
    end
    start = 1'b0;
    check("ignored_start_latency", lat, 32'd33);
    check("ignored_start_result", result, 32'd99);
    repeat (40) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    check("ignored_start_no_extra_done", pulses, 32'd0);

    // flush + start in IDLE: start discarded.
    start = 1'b1; flush = 1'b1; rs1 = 32'd2; rs2 = 32'd2;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    check("flush_start_idle_busy", {31'd0, busy}, 32'd0);

    // flush mid-operation at cycle 15.
    start = 1'b1; op = 2'b00; rs1 = 32'd1000; rs2 = 32'd1000;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (15) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_busy", {31'd0, busy}, 32'd0);
    check("flush_done", {31'd0, done}, 32'd0);
    pulses = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    check("flush_no_done", pulses, 32'd0);
    check("flush_result_kept", result, 32'd99);

    // Async reset mid-operation.
    start = 1'b1; op = 2'b11; rs1 = 32'hFFFFFFFF; rs2 = 32'hFFFFFFFF;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    #3 rst = 1'b1;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_result", result, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    pulses = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    check("arst_no_done", pulses, 32'd0);

    run_op(2'b00, 32'd3, 32'd5, lat, bm);
    check("post_rst_latency", lat, 32'd33);
    check("post_rst_result", result, 32'h0000000F);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
